// File: rtl/obstacle_pool.sv
// ============================================================================
// obstacle_pool : obstacle record pool with spawn gap and speed ramp
// Revision      : 1.0
// ============================================================================
`default_nettype none

module obstacle_pool #(
    parameter int SLOTS         = 4,
    parameter int XW            = 10,
    parameter int YW            = 9,
    parameter int WW            = 6,
    parameter int HW            = 6,
    parameter int SCREEN_W      = 640,
    parameter int RANDW         = 8,
    parameter int SPAWN_BITS    = 4,
    parameter int MIN_GAP       = 40,
    parameter int SPEED_INIT    = 2,
    parameter int SPEED_MAX     = 8,
    parameter int RAMP_FRAMES   = 512,
    parameter int FLY_MIN_SPEED = 4,
    parameter int GROUND_Y      = 400,
    parameter int GROUND_W      = 20,
    parameter int GROUND_H      = 40,
    parameter int FLY_Y         = 340,
    parameter int FLY_W         = 30,
    parameter int FLY_H         = 20
) (
    input  logic                  clk3,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  pause,
    input  logic                  start,
    input  logic [RANDW-1:0]      rand_in,
    output logic [SLOTS-1:0]      obj_valid,
    output logic [SLOTS-1:0]      obj_kind,
    output logic [SLOTS*XW-1:0]   obj_x,
    output logic [SLOTS*YW-1:0]   obj_y,
    output logic [SLOTS*WW-1:0]   obj_w,
    output logic [SLOTS*HW-1:0]   obj_h,
    output logic [3:0]            speed,
    output logic                  pool_full,
    output logic                  spawn_pulse,
    output logic [15:0]           passed_count
);

    localparam int c_RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam int c_CW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [c_RW-1:0] c_RAMP_LAST  = c_RW'(RAMP_FRAMES - 1);
    localparam logic [c_CW-1:0] c_GAP_LOAD   = c_CW'(MIN_GAP - 1);
    localparam logic [3:0]      c_SPEED_INIT = 4'(SPEED_INIT);
    localparam logic [3:0]      c_SPEED_MAX  = 4'(SPEED_MAX);
    localparam logic [3:0]      c_FLY_MIN    = 4'(FLY_MIN_SPEED);
    localparam logic [XW-1:0]   c_SCREEN_W   = XW'(SCREEN_W);
    localparam logic [YW-1:0]   c_GROUND_Y   = YW'(GROUND_Y);
    localparam logic [WW-1:0]   c_GROUND_W   = WW'(GROUND_W);
    localparam logic [HW-1:0]   c_GROUND_H   = HW'(GROUND_H);
    localparam logic [YW-1:0]   c_FLY_Y      = YW'(FLY_Y);
    localparam logic [WW-1:0]   c_FLY_W      = WW'(FLY_W);
    localparam logic [HW-1:0]   c_FLY_H      = HW'(FLY_H);

    logic              w_run;
    logic [SLOTS-1:0]  w_free;
    logic [SLOTS-1:0]  w_grant;
    logic [SLOTS-1:0]  w_despawn;
    logic              w_spawn;
    logic              w_fly;
    logic [XW-1:0]     w_speed_x;
    logic [4:0]        w_dcount;
    logic [16:0]       w_passed_sum;

    logic [3:0]        r_speed;
    logic [c_RW-1:0]   r_ramp;
    logic [c_CW-1:0]   r_cool;
    logic [15:0]       r_passed;
    logic              r_pulse;

    assign w_run     = start & ~pause & ~clear;
    assign w_free    = ~obj_valid;
    // Isolate the lowest set bit: only the lowest-index free slot may spawn.
    assign w_grant   = w_free & (~w_free + SLOTS'(1));
    assign w_spawn   = w_run && (r_cool == '0) && (rand_in[SPAWN_BITS-1:0] == '0) && (|w_free);
    assign w_fly     = rand_in[RANDW-1] && (r_speed >= c_FLY_MIN);
    assign w_speed_x = XW'(r_speed);

    always_comb begin
        w_dcount = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_dcount = w_dcount + 5'(w_despawn[i]);
        end
    end

    assign w_passed_sum = {1'b0, r_passed} + 17'(w_dcount);

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic          r_valid;
            logic          r_kind;
            logic [XW-1:0] r_x;
            logic [YW-1:0] r_y;
            logic [WW-1:0] r_w;
            logic [HW-1:0] r_h;

            // Compare before subtracting so x never wraps below zero.
            assign w_despawn[gi] = w_run & r_valid & (r_x <= w_speed_x);

            always_ff @(posedge clk3 or negedge reset) begin
                if (!reset) begin
                    r_valid <= 1'b0;
                    r_kind  <= 1'b0;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_w     <= '0;
                    r_h     <= '0;
                end else if (clear) begin
                    r_valid <= 1'b0;
                    r_kind  <= 1'b0;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_w     <= '0;
                    r_h     <= '0;
                end else if (w_run) begin
                    if (w_spawn && w_grant[gi]) begin
                        r_valid <= 1'b1;
                        r_kind  <= w_fly;
                        r_x     <= c_SCREEN_W;
                        r_y     <= w_fly ? c_FLY_Y : c_GROUND_Y;
                        r_w     <= w_fly ? c_FLY_W : c_GROUND_W;
                        r_h     <= w_fly ? c_FLY_H : c_GROUND_H;
                    end else if (w_despawn[gi]) begin
                        r_valid <= 1'b0;
                    end else if (r_valid) begin
                        r_x <= r_x - w_speed_x;
                    end
                end
            end

            assign obj_valid[gi]          = r_valid;
            assign obj_kind[gi]           = r_kind;
            assign obj_x[gi*XW +: XW]     = r_x;
            assign obj_y[gi*YW +: YW]     = r_y;
            assign obj_w[gi*WW +: WW]     = r_w;
            assign obj_h[gi*HW +: HW]     = r_h;
        end
    endgenerate

    always_ff @(posedge clk3 or negedge reset) begin
        if (!reset) begin
            r_speed  <= c_SPEED_INIT;
            r_ramp   <= '0;
            r_cool   <= '0;
            r_passed <= '0;
            r_pulse  <= 1'b0;
        end else if (clear) begin
            r_speed  <= c_SPEED_INIT;
            r_ramp   <= '0;
            r_cool   <= '0;
            r_passed <= '0;
            r_pulse  <= 1'b0;
        end else if (w_run) begin
            r_pulse  <= w_spawn;
            r_passed <= w_passed_sum[16] ? 16'hFFFF : w_passed_sum[15:0];
            if (w_spawn) begin
                r_cool <= c_GAP_LOAD;
            end else if (r_cool != '0) begin
                r_cool <= r_cool - c_CW'(1);
            end
            if (r_ramp == c_RAMP_LAST) begin
                r_ramp <= '0;
                if (r_speed < c_SPEED_MAX) begin
                    r_speed <= r_speed + 4'd1;
                end
            end else begin
                r_ramp <= r_ramp + c_RW'(1);
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign speed        = r_speed;
    assign pool_full    = &obj_valid;
    assign spawn_pulse  = r_pulse;
    assign passed_count = r_passed;

endmodule

`default_nettype wire

// File: doc/obstacle_pool.md
# obstacle_pool

Parametrised obstacle manager for the dinosaur game. It owns a pool of `SLOTS` obstacle records and advances them once per `clk3` frame tick. It spawns ground or flying obstacles from the random source, enforces a minimum spawn gap, and ramps scroll speed over time. It reports passed obstacles to the scorer and drives per-slot record buses to the renderer and collision logic as plain outputs (no shared inout bus).

## Interface
- `SLOTS`, 4: number of obstacle records (1..16)
- `XW`, 10: x coordinate width
- `YW`, 9: y coordinate width
- `WW`, 6: width field width
- `HW`, 6: height field width
- `SCREEN_W`, 640: spawn x position
- `RANDW`, 8: random input width
- `SPAWN_BITS`, 4: spawn is requested when `rand_in[SPAWN_BITS-1:0]==0`
- `MIN_GAP`, 40: minimum frames between spawns (>=1)
- `SPEED_INIT`, 2: initial pixels/frame
- `SPEED_MAX`, 8: speed ceiling
- `RAMP_FRAMES`, 512: run frames per speed step
- `FLY_MIN_SPEED`, 4: flying obstacles allowed only at speed >= this
- `GROUND_Y`, 400 / `GROUND_W`, 20 / `GROUND_H`, 40: ground obstacle geometry
- `FLY_Y`, 340 / `FLY_W`, 30 / `FLY_H`, 20: flying obstacle geometry

Ports:
- `clk3` in 1: frame clock
- `reset` in 1: reset, asynchronous, active-low
- `clear` in 1: synchronous game restart, active-high
- `pause` in 1: freeze when high
- `start` in 1: game running when high
- `rand_in` in RANDW: fresh random word each frame
- `obj_valid` out SLOTS: slot occupied
- `obj_kind` out SLOTS: 0 ground, 1 flying
- `obj_x` out SLOTS*XW: slot i at `[i*XW +: XW]`
- `obj_y` out SLOTS*YW; `obj_w` out SLOTS*WW; `obj_h` out SLOTS*HW
- `speed` out 4: current pixels/frame
- `pool_full` out 1: all slots valid (combinational from `obj_valid`)
- `spawn_pulse` out 1: high one frame after a spawn
- `passed_count` out 16: obstacles scrolled off, saturating at 0xFFFF

## Operation
- `run = start & ~pause & ~clear`. When `run==0` all state holds, except that `clear` resets it.
- Reset/clear state:
  - `obj_valid`=0; all x/y/w/h/kind fields 0.
  - `speed=SPEED_INIT`; cooldown 0; ramp counter 0.
  - `passed_count`=0; `spawn_pulse`=0.
- Movement (each run frame, every valid slot, using the pre-update `speed`):
  - if `x <= speed`: slot invalidated, `passed_count` += 1 (saturating). Multiple despawns in one frame add their count.
  - else `x <= x - speed`. No wrap-around is permitted.
- Spawn:
  - Condition: cooldown==0, `rand_in[SPAWN_BITS-1:0]==0`, and at least one slot invalid *before* this frame's update. A slot freed this frame is not reusable until next frame.
  - Target: lowest-index free slot only.
  - Kind: flying if `rand_in[RANDW-1]==1` and `speed>=FLY_MIN_SPEED`, else ground.
  - Fields loaded: x=`SCREEN_W`, plus the matching y/w/h constants.
  - On spawn: cooldown loads `MIN_GAP-1` and `spawn_pulse`=1 next cycle.
  - Pool full with request: spawn dropped, cooldown unchanged, no pulse.
- Cooldown: decrements each run frame while nonzero. Spawn frames N, earliest next spawn N+MIN_GAP.
- Speed ramp: ramp counter counts run frames 0..RAMP_FRAMES-1. On wrap, `speed` += 1 if `speed<SPEED_MAX`, else holds. The new speed applies from the following frame.

## Timing
- All registered outputs update on posedge `clk3`; `reset` acts immediately and asynchronously.
- Latency:
  - spawn condition at edge N: record visible after edge N.
  - first movement at edge N+1.
- `clear` has priority over `run`; `reset` has priority over everything.
- Reset asserted mid-frame drops any pending spawn or despawn; no partial record update.
- Simultaneous despawn of slot k and spawn request: the spawn goes to another free slot if one existed before the update, otherwise it is dropped.

## Test plan
- Reset then `start=1`, `rand_in`=0 constantly: slot 0 spawns at edge 1 (x=640, y=400, w=20, h=40). Slot 1 spawns at edge 41; slot 0 x=640-2*40=560 at that time.
- Four spawns, then keep requesting at gap: `pool_full`=1 and the request is dropped with no `spawn_pulse`. After slot 0 reaches x<=2 it frees and `passed_count`=1. The next request fills slot 0.
- Slot at x=3, speed 2: x becomes 1, then despawns next frame (no underflow to 1023). `passed_count` increments exactly once.
- 512 run frames: speed 2->3. 3072 frames total: saturates at 8. With `pause=1` for 100 frames mid-run: ramp counter, x and cooldown unchanged.
- `rand_in[7]=1` with speed 2: ground obstacle spawns. With speed 4: flying obstacle, y=340, w=30, h=20.
- `clear` pulse mid-game with 3 live obstacles: next cycle all valid=0, `speed`=2, `passed_count`=0. Async `reset` low mid-frame clears outputs before the next edge.
